// File: rtl/seq_pkg.sv
// Shared constants and types for the sequence-length JTAG path (write under IR_SEQ, readback under IR_RB).
// SEQ_RB_PARITY_EN appends an even-parity bit to the readback frame.
package seq_pkg;

  localparam int unsigned IR_W = 3;
  localparam logic [IR_W-1:0] IR_SEQ = 3'b111;
  localparam logic [IR_W-1:0] IR_RB  = 3'b110;

  // Readback field map, LSB first
  localparam int unsigned SEQ_LEN_LSB  = 0;
  localparam int unsigned SEQ_LEN_W    = 10;
  localparam int unsigned DIV_BASE_LSB = 10;
  localparam int unsigned DIV_BASE_W   = 5;
  localparam int unsigned GEN_STAT_LSB = 15;
  localparam int unsigned GEN_STAT_W   = 4;
  localparam int unsigned RD_CNT_LSB   = 19;
  localparam int unsigned RD_CNT_W     = 4;
  localparam int unsigned OVR_LSB      = 23;
  localparam int unsigned FRAME_W      = 24;

`ifdef SEQ_RB_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned RB_W   = FRAME_W + PAR_W;
  localparam int unsigned BCNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAP   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FULL  = 2'd3
  } rb_state_e;

  typedef struct packed {
    logic                  ovr;
    logic [RD_CNT_W-1:0]   rd_cnt;
    logic [GEN_STAT_W-1:0] gen_status;
    logic [DIV_BASE_W-1:0] div_base;
    logic [SEQ_LEN_W-1:0]  seq_length;
  } rb_frame_t;

endpackage

// File: rtl/seq_readback_if.sv
// Virtual JTAG hub signals seen by the readback responder; master = hub, slave = responder.
interface seq_readback_if;
  import seq_pkg::*;

  logic            tdi;
  logic [IR_W-1:0] ir_in;
  logic            v_cdr;
  logic            v_sdr;
  logic            v_udr;
  logic            tdo;

  modport master (output tdi, ir_in, v_cdr, v_sdr, v_udr, input tdo);
  modport slave  (input tdi, ir_in, v_cdr, v_sdr, v_udr, output tdo);

endinterface

// File: rtl/seq_readback_rb_frame_pack.sv
// Combinational packer for the readback frame; adds even parity when SEQ_RB_PARITY_EN is defined.
module rb_frame_pack
  import seq_pkg::*;
(
  input  logic [SEQ_LEN_W-1:0]  seq_length_i,
  input  logic [DIV_BASE_W-1:0] div_base_i,
  input  logic [GEN_STAT_W-1:0] gen_status_i,
  input  logic [RD_CNT_W-1:0]   rd_cnt_i,
  input  logic                  ovr_i,
  output logic [RB_W-1:0]       frame_c
);

  rb_frame_t fields;

  always_comb begin
    fields            = '0;
    fields.seq_length = seq_length_i;
    fields.div_base   = div_base_i;
    fields.gen_status = gen_status_i;
    fields.rd_cnt     = rd_cnt_i;
    fields.ovr        = ovr_i;
  end

`ifdef SEQ_RB_PARITY_EN
  // Parity bit makes the XOR over the whole streamed frame zero
  assign frame_c = {^fields, fields};
`else
  assign frame_c = fields;
`endif

endmodule

// File: rtl/seq_readback.sv
// JTAG virtual-IR readback responder: captures seq_length/div_base/status under IR_RB and shifts out LSB-first.
// SEQ_RB_PARITY_EN widens the frame by one even-parity bit.
module seq_readback
  import seq_pkg::*;
#(
  parameter int unsigned FRAME_W = seq_pkg::FRAME_W
) (
  input  logic                  tck,
  input  logic                  aclr_n,
  seq_readback_if.slave         hub,
  input  logic [SEQ_LEN_W-1:0]  seq_length,
  input  logic [DIV_BASE_W-1:0] div_base,
  input  logic [GEN_STAT_W-1:0] gen_status,
  output logic                  rb_busy
);

  localparam int unsigned W = FRAME_W + PAR_W;

  rb_state_e           st_q;
  logic [W-1:0]        sr_q;
  logic                byp_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [RD_CNT_W-1:0] rd_cnt_q;
  logic                ovr_q;

  logic                ir_sel;
  logic [W-1:0]        frame_c;
  logic [BCNT_W-1:0]   bcnt_inc;
  logic                full_read;

  assign ir_sel    = (hub.ir_in == IR_RB);
  assign bcnt_inc  = (bcnt_q == '1) ? bcnt_q : bcnt_q + BCNT_W'(1);
  // Only an exact-length read under the readback IR counts as complete
  assign full_read = ir_sel && (bcnt_q == BCNT_W'(W));

  rb_frame_pack u_pack (
    .seq_length_i (seq_length),
    .div_base_i   (div_base),
    .gen_status_i (gen_status),
    .rd_cnt_i     (rd_cnt_q),
    .ovr_i        (ovr_q),
    .frame_c      (frame_c)
  );

  // Priority: update, then capture, then shift
  always_ff @(posedge tck or negedge aclr_n) begin
    if (!aclr_n) begin
      st_q     <= ST_IDLE;
      sr_q     <= '0;
      byp_q    <= 1'b0;
      bcnt_q   <= '0;
      rd_cnt_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      byp_q <= hub.tdi;
      if (hub.v_udr) begin
        st_q <= ST_IDLE;
        if (st_q != ST_IDLE && full_read) begin
          rd_cnt_q <= rd_cnt_q + RD_CNT_W'(1);
        end
      end else if (ir_sel && hub.v_cdr) begin
        st_q   <= ST_CAP;
        sr_q   <= frame_c;
        bcnt_q <= '0;
        ovr_q  <= 1'b0;
      end else if (ir_sel && hub.v_sdr && st_q != ST_IDLE) begin
        sr_q   <= {hub.tdi, sr_q[W-1:1]};
        bcnt_q <= bcnt_inc;
        if (st_q == ST_FULL) begin
          ovr_q <= 1'b1;
        end else if (bcnt_inc == BCNT_W'(W)) begin
          st_q <= ST_FULL;
        end else begin
          st_q <= ST_SHIFT;
        end
      end
    end
  end

  assign hub.tdo = ir_sel ? sr_q[0] : byp_q;
  assign rb_busy = (st_q != ST_IDLE);

endmodule

// File: tb/tb_seq_readback.sv
// Directed + randomized bench for seq_readback against a field-level frame model.
module tb_seq_readback;
  import seq_pkg::*;

  localparam int unsigned W = RB_W;

  logic                  tck = 1'b0;
  logic                  aclr_n;
  logic [SEQ_LEN_W-1:0]  seq_length;
  logic [DIV_BASE_W-1:0] div_base;
  logic [GEN_STAT_W-1:0] gen_status;
  logic                  rb_busy;

  seq_readback_if hub();

  seq_readback dut (
    .tck        (tck),
    .aclr_n     (aclr_n),
    .hub        (hub),
    .seq_length (seq_length),
    .div_base   (div_base),
    .gen_status (gen_status),
    .rb_busy    (rb_busy)
  );

  always #5 tck = ~tck;

  int          total = 0;
  int          bad   = 0;
  int          m_rd  = 0;
  int          m_ovr = 0;
  int          nshift = 0;
  bit          exp_q[$];
  logic [31:0] exp_frame;
  logic [31:0] obs_frame;

  function automatic logic [31:0] model_frame(input int unsigned sl, input int unsigned db,
                                              input int unsigned gs, input int unsigned rd,
                                              input int unsigned ov);
    int unsigned f;
    f = sl + db * 1024 + gs * 32768 + rd * 524288 + ov * 8388608;
    if (W > FRAME_W) f = f + (($countones(f) % 2) * 16777216);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit cdr, input bit sdr, input bit udr, input bit t);
    hub.v_cdr = cdr;
    hub.v_sdr = sdr;
    hub.v_udr = udr;
    hub.tdi   = t;
    @(posedge tck);
    #1;
    hub.v_cdr = 1'b0;
    hub.v_sdr = 1'b0;
    hub.v_udr = 1'b0;
  endtask

  task automatic capture(input bit with_sdr, input bit rnd);
    if (rnd) begin
      seq_length = 10'($urandom);
      div_base   = 5'($urandom);
      gen_status = 4'($urandom);
    end
    exp_frame = model_frame(seq_length, div_base, gen_status, m_rd, m_ovr);
    exp_q.delete();
    for (int k = 0; k < W; k++) exp_q.push_back(exp_frame[k]);
    m_ovr  = 0;
    nshift = 0;
    drive(1'b1, with_sdr, 1'b0, 1'($urandom));
    obs_frame    = '0;
    obs_frame[0] = hub.tdo;
    chk("cap_busy", 32'(rb_busy), 32'd1);
    chk("cap_tdo", 32'(hub.tdo), 32'(exp_q[0]));
    // inputs after the capture edge must not leak into the frame
    seq_length = 10'($urandom);
    div_base   = 5'($urandom);
    gen_status = 4'($urandom);
  endtask

  task automatic shift(input int n);
    for (int i = 0; i < n; i++) begin
      bit t;
      t = 1'($urandom);
      drive(1'b0, 1'b1, 1'b0, t);
      exp_q.push_back(t);
      void'(exp_q.pop_front());
      nshift++;
      if (nshift > int'(W)) m_ovr = 1;
      if (nshift < int'(W)) obs_frame[nshift] = hub.tdo;
      chk("shift_tdo", 32'(hub.tdo), 32'(exp_q[0]));
      chk("shift_busy", 32'(rb_busy), 32'd1);
    end
  endtask

  task automatic update();
    drive(1'b0, 1'b0, 1'b1, 1'($urandom));
    if (nshift == int'(W)) m_rd = (m_rd + 1) % 16;
    chk("upd_busy", 32'(rb_busy), 32'd0);
  endtask

  task automatic full_read(input bit rnd);
    capture(1'b0, rnd);
    shift(int'(W));
    chk("frame", obs_frame, exp_frame);
    update();
  endtask

  initial begin
    hub.tdi    = 1'b1;
    hub.ir_in  = IR_RB;
    hub.v_cdr  = 1'b0;
    hub.v_sdr  = 1'b0;
    hub.v_udr  = 1'b0;
    seq_length = '0;
    div_base   = '0;
    gen_status = '0;
    aclr_n     = 1'b0;
    #2;
    chk("rst_tdo", 32'(hub.tdo), 32'd0);
    chk("rst_busy", 32'(rb_busy), 32'd0);
    #10;
    aclr_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Directed first frame
    seq_length = 10'h2A5;
    div_base   = 5'h13;
    gen_status = 4'h9;
    capture(1'b0, 1'b0);
    shift(int'(W));
    chk("first_frame", obs_frame, exp_frame);
    chk("first_rd", 32'(obs_frame[RD_CNT_LSB +: RD_CNT_W]), 32'd0);
`ifdef SEQ_RB_PARITY_EN
    chk("par_xor", 32'(^obs_frame), 32'd0);
`endif
    update();

    // Count accumulation and wrap
    for (int r = 0; r < 3; r++) full_read(1'b1);
    capture(1'b0, 1'b1);
    shift(int'(W));
    chk("rd_after_reads", 32'(obs_frame[RD_CNT_LSB +: RD_CNT_W]), 32'd4);
    update();
    for (int r = 0; r < 15; r++) full_read(1'b1);
    capture(1'b0, 1'b1);
    shift(int'(W));
    chk("rd_wrapped", 32'(obs_frame[RD_CNT_LSB +: RD_CNT_W]), 32'd4);
    update();

    // Overshift sets sticky ovr, not counted; next capture clears it
    capture(1'b0, 1'b1);
    shift(int'(W) + 2);
    update();
    full_read(1'b1);
    chk("ovr_set", 32'(obs_frame[OVR_LSB]), 32'd1);
    chk("ovr_rd", 32'(obs_frame[RD_CNT_LSB +: RD_CNT_W]), 32'd5);
    full_read(1'b1);
    chk("ovr_clr", 32'(obs_frame[OVR_LSB]), 32'd0);

    // Short read does not count
    capture(1'b0, 1'b1);
    shift(int'(W) - 1);
    update();
    full_read(1'b1);

    // Other IR: strobes ignored, tdo is the one-tck bypass
    hub.ir_in = IR_SEQ;
    for (int i = 0; i < 10; i++) begin
      bit t;
      t = 1'($urandom);
      drive(1'($urandom), 1'($urandom), 1'b0, t);
      chk("byp_tdo", 32'(hub.tdo), 32'(t));
      chk("byp_busy", 32'(rb_busy), 32'd0);
    end
    hub.ir_in = IR_RB;
    full_read(1'b1);

    // Capture and shift together: capture only
    capture(1'b1, 1'b1);
    shift(int'(W));
    chk("cap_sdr_frame", obs_frame, exp_frame);
    update();

    // IR leaves readback mid-frame: state held, update ends it uncounted
    capture(1'b0, 1'b1);
    shift(5);
    hub.ir_in = IR_SEQ;
    for (int i = 0; i < 3; i++) begin
      bit t;
      t = 1'($urandom);
      drive(1'b0, 1'b1, 1'b0, t);
      chk("mid_busy", 32'(rb_busy), 32'd1);
      chk("mid_byp", 32'(hub.tdo), 32'(t));
    end
    hub.ir_in = IR_RB;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_held", 32'(hub.tdo), 32'(exp_q[0]));
    update();
    full_read(1'b1);

    // Reset mid-shift clears everything
    capture(1'b0, 1'b1);
    shift(7);
    #2;
    aclr_n = 1'b0;
    #1;
    chk("amid_tdo", 32'(hub.tdo), 32'd0);
    chk("amid_busy", 32'(rb_busy), 32'd0);
    m_rd  = 0;
    m_ovr = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    aclr_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    full_read(1'b1);
    chk("rst_rd", 32'(obs_frame[RD_CNT_LSB +: RD_CNT_W]), 32'd0);
    chk("rst_ovr", 32'(obs_frame[OVR_LSB]), 32'd0);
    full_read(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
